// File: rtl/layer_pkg.sv
// layer_pkg: shared default widths, signed saturation helper and output lane count (LAYER_POOL_EN selects per-filter max-pool)
package layer_pkg;
    localparam int DEF_NUM_F   = 4;
    localparam int DEF_NUM_PIX = 4;
    localparam int DEF_PSUM_W  = 23;
    localparam int DEF_ACC_W   = 32;
    localparam int DEF_BIAS_W  = 16;
    localparam int DEF_OUT_W   = 8;
    localparam int DEF_SHIFT_W = 5;
`ifdef LAYER_POOL_EN
    localparam bit POOL_EN = 1'b1;
`else
    localparam bit POOL_EN = 1'b0;
`endif
    localparam int OUT_PIX = POOL_EN ? 1 : DEF_NUM_PIX;

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return value > hi ? hi : (value < lo ? lo : value);
    endfunction
endpackage

// File: rtl/quant_lane.sv
// quant_lane: one lane of round-half-up shift requantisation with optional ReLU and output saturation
module quant_lane import layer_pkg::*; #(
    parameter int ACC_W   = DEF_ACC_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int SHIFT_W = DEF_SHIFT_W
) (
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic [SHIFT_W-1:0]      i_shift,
    input  logic                    i_relu_en,
    output logic signed [OUT_W-1:0] o_val,
    output logic                    o_clamp
);
    logic [ACC_W:0]        half;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] shr;
    logic signed [ACC_W:0] rel;
    logic signed [63:0]    wide;
    logic signed [63:0]    sat;

    // add rounding half in one extra bit, arithmetic shift, ReLU, clamp to OUT_W
    always_comb begin
        half    = (i_shift == '0) ? '0 : ((ACC_W+1)'(1) << (i_shift - 1'b1));
        rnd     = $signed({i_acc[ACC_W-1], i_acc}) + $signed(half);
        shr     = rnd >>> i_shift;
        rel     = (i_relu_en && shr < 0) ? '0 : shr;
        wide    = 64'(rel);
        sat     = sat_signed(wide, OUT_W);
        o_val   = OUT_W'(sat);
        o_clamp = sat != wide;
    end
endmodule

// File: rtl/layer_acc_quant.sv
// layer_acc_quant: multi-pass psum accumulator with bias, requantisation and valid/ready output (LAYER_POOL_EN adds per-filter max-pool)
module layer_acc_quant import layer_pkg::*; #(
    parameter int NUM_F   = DEF_NUM_F,
    parameter int NUM_PIX = DEF_NUM_PIX,
    parameter int PSUM_W  = DEF_PSUM_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int BIAS_W  = DEF_BIAS_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int SHIFT_W = DEF_SHIFT_W,
    localparam int OPIX   = POOL_EN ? 1 : NUM_PIX
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_vld,
    output logic                             o_rdy,
    input  logic                             i_first,
    input  logic                             i_last,
    input  logic [NUM_F*NUM_PIX*PSUM_W-1:0]  i_psum,
    input  logic [NUM_F*BIAS_W-1:0]          i_bias,
    input  logic [SHIFT_W-1:0]               i_shift,
    input  logic                             i_relu_en,
    output logic                             o_vld,
    input  logic                             i_rdy,
    output logic [NUM_F*OPIX*OUT_W-1:0]      o_data,
    output logic                             o_sat
);
    localparam int LANES = NUM_F * NUM_PIX;

    logic signed [ACC_W-1:0] acc_q [LANES];
    logic signed [ACC_W-1:0] acc_d [LANES];
    logic signed [63:0]      sum   [LANES];
    logic signed [63:0]      clp   [LANES];
    logic signed [OUT_W-1:0] qv    [LANES];
    logic [LANES-1:0]        qc;
    logic [SHIFT_W-1:0]      shift_q, shift_d;
    logic                    relu_q, relu_d;
    logic                    sticky_q, sticky_d;
    logic                    done_q, done_d;
    logic                    o_vld_q, o_vld_d;
    logic                    o_sat_q, o_sat_d;
    logic [NUM_F*OPIX*OUT_W-1:0] o_data_q, o_data_d, q_pack;
    logic                    acc_en, load, acc_clamp;

    assign load   = done_q & (~o_vld_q | i_rdy);
    assign o_rdy  = ~done_q | ~o_vld_q | i_rdy;
    assign acc_en = i_vld & o_rdy;
    assign o_vld  = o_vld_q;
    assign o_data = o_data_q;
    assign o_sat  = o_sat_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        quant_lane #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) u_lane (
            .i_acc(acc_q[g]),
            .i_shift(shift_q),
            .i_relu_en(relu_q),
            .o_val(qv[g]),
            .o_clamp(qc[g])
        );
    end

`ifdef LAYER_POOL_EN
    logic signed [OUT_W-1:0] mx;
    // keep the largest quantised pixel of each filter
    always_comb begin
        q_pack = '0;
        mx     = '0;
        for (int f = 0; f < NUM_F; f++) begin
            mx = qv[f*NUM_PIX];
            for (int p = 1; p < NUM_PIX; p++)
                mx = (qv[f*NUM_PIX+p] > mx) ? qv[f*NUM_PIX+p] : mx;
            q_pack[f*OUT_W +: OUT_W] = mx;
        end
    end
`else
    // pass every quantised lane straight through in f/p order
    always_comb begin
        q_pack = '0;
        for (int i = 0; i < LANES; i++)
            q_pack[i*OUT_W +: OUT_W] = qv[i];
    end
`endif

    // accumulate a beat (bias on the first pass), clamp to ACC_W, and sequence output loads
    always_comb begin
        acc_clamp = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            sum[i] = 64'($signed(i_psum[i*PSUM_W +: PSUM_W]))
                   + (i_first ? 64'($signed(i_bias[(i/NUM_PIX)*BIAS_W +: BIAS_W])) : 64'(acc_q[i]));
            clp[i] = sat_signed(sum[i], ACC_W);
            acc_clamp = acc_clamp | (clp[i] != sum[i]);
            acc_d[i] = acc_en ? ACC_W'(clp[i]) : acc_q[i];
        end
        sticky_d = acc_en ? ((i_first ? 1'b0 : sticky_q) | acc_clamp) : sticky_q;
        shift_d  = (acc_en & i_last) ? i_shift : shift_q;
        relu_d   = (acc_en & i_last) ? i_relu_en : relu_q;
        done_d   = (acc_en & i_last) | (done_q & ~load);
        o_vld_d  = load | (o_vld_q & ~i_rdy);
        o_data_d = load ? q_pack : o_data_q;
        o_sat_d  = load ? (sticky_q | (|qc)) : o_sat_q;
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++)
                acc_q[i] <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            sticky_q <= 1'b0;
            done_q   <= 1'b0;
            o_vld_q  <= 1'b0;
            o_data_q <= '0;
            o_sat_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            shift_q  <= shift_d;
            relu_q   <= relu_d;
            sticky_q <= sticky_d;
            done_q   <= done_d;
            o_vld_q  <= o_vld_d;
            o_data_q <= o_data_d;
            o_sat_q  <= o_sat_d;
        end
    end
endmodule
